// File: rtl/bitstream_pkg.sv
// Shared types for the stochastic bitstream neuron: FSM states and
// maximal-length Fibonacci LFSR tap masks for widths 8..32.
package bitstream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Tap mask: bit (p-1) set for each tap position p of a maximal-length polynomial.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_00B8;
    endcase
  endfunction

endpackage

// File: rtl/bitstream_neuron_acc_sng.sv
// Stochastic number generator: free-running LFSR compared against a stored value.
module sng
  import bitstream_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEED  = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] value,
  output logic             bit_o
);

  localparam logic [31:0]      TAPS32 = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS   = TAPS32[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);
  // All-zero is the lock-up state of an XOR LFSR, so never seed it.
  localparam logic [WIDTH-1:0] INIT   = (SEED_W == '0) ? WIDTH'(1) : SEED_W;

  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) lfsr_q <= INIT;
    else        lfsr_q <= lfsr_d;
  end

  assign bit_o = (lfsr_q <= value);

endmodule

// File: rtl/bitstream_neuron_acc.sv
// Stochastic bitstream neuron: unipolar AND/OR or bipolar XNOR/MUX with
// saturating-counter ReLU, counting output ones over a 2^STREAM_LOG2 window.
module bitstream_neuron_acc
  import bitstream_pkg::*;
#(
  parameter int INPUT_SIZE  = 4,
  parameter int WIDTH       = 16,
  parameter int STREAM_LOG2 = 8,
  parameter int ACT_BITS    = 3,
  parameter int SEED        = 0
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           cfg_bipolar,
  input  logic                           start,
  input  logic                           wr_en,
  input  logic [$clog2(INPUT_SIZE+1)-1:0] wr_addr,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic [INPUT_SIZE-1:0]          neuron_input,
  output logic                           neuron_output,
  output logic                           busy,
  output logic [STREAM_LOG2:0]           count_out,
  output logic                           count_valid
);

  localparam int                   AW        = $clog2(INPUT_SIZE+1);
  localparam logic [AW-1:0]        BIAS_ADDR = AW'(INPUT_SIZE);
  localparam logic [STREAM_LOG2:0] WIN       = {1'b1, {STREAM_LOG2{1'b0}}};
  localparam logic [ACT_BITS-1:0]  MID       = {1'b1, {(ACT_BITS-1){1'b0}}};
  localparam logic [ACT_BITS-1:0]  MAX       = '1;

  state_e                          state_q, state_d;
  logic [INPUT_SIZE:0][WIDTH-1:0]  w_q, w_d;
  logic [STREAM_LOG2:0]            cyc_q, cyc_d, ones_q, ones_d, cnt_q, cnt_d;
  logic [AW-1:0]                   sel_q, sel_d;
  logic [ACT_BITS-1:0]             s_q, s_d;
  logic                            tog_q, tog_d, mode_q, mode_d;
  logic                            out_q, out_d, cv_q, cv_d;
  logic [INPUT_SIZE:0]             sbit, mux_in;
  logic                            sum, act;

  // Slot INPUT_SIZE of the register file and SNG array is the bias.
  for (genvar k = 0; k <= INPUT_SIZE; k++) begin : g_sng
    sng #(.WIDTH(WIDTH), .SEED(SEED + k + 1)) u_sng (
      .clk   (clk),
      .n_rst (n_rst),
      .value (w_q[k]),
      .bit_o (sbit[k])
    );
  end

  always_comb begin
    mux_in = {sbit[INPUT_SIZE], ~(sbit[INPUT_SIZE-1:0] ^ neuron_input)};
    if (mode_q) begin
      sum = mux_in[sel_q];
      act = (s_q >= MID) ? sum : tog_q;
    end else begin
      sum = sbit[INPUT_SIZE] | (|(sbit[INPUT_SIZE-1:0] & neuron_input));
      act = sum;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cyc_d   = cyc_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    s_d     = s_q;
    tog_d   = tog_q;
    mode_d  = mode_q;
    out_d   = 1'b0;
    cv_d    = 1'b0;
    if (state_q == IDLE && wr_en && wr_addr <= BIAS_ADDR) w_d[wr_addr] = wr_data;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        mode_d  = cfg_bipolar;
        cyc_d   = '0;
        ones_d  = '0;
        sel_d   = '0;
        tog_d   = 1'b0;
        s_d     = MID;
      end
      RUN: begin
        cyc_d = cyc_q + 1'b1;
        // out_q lags act by one cycle, so sampling starts at index 1.
        if (cyc_q != '0) ones_d = ones_q + {{STREAM_LOG2{1'b0}}, out_q};
        if (cyc_q == WIN) begin
          state_d = DONE;
          cnt_d   = ones_d;
          cv_d    = 1'b1;
        end else begin
          out_d = act;
          sel_d = (sel_q == BIAS_ADDR) ? '0 : sel_q + 1'b1;
          tog_d = ~tog_q;
          if (sum && s_q != MAX)       s_d = s_q + 1'b1;
          else if (!sum && s_q != '0)  s_d = s_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      cyc_q   <= '0;
      ones_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      s_q     <= MID;
      tog_q   <= 1'b0;
      mode_q  <= 1'b0;
      out_q   <= 1'b0;
      cv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cyc_q   <= cyc_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      s_q     <= s_d;
      tog_q   <= tog_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      cv_q    <= cv_d;
    end
  end

  assign neuron_output = out_q;
  assign busy          = (state_q != IDLE);
  assign count_out     = cnt_q;
  assign count_valid   = cv_q;

endmodule

// File: tb/tb_bitstream_neuron_acc.sv
// Bench for bitstream_neuron_acc: weights restricted to 0 / all-ones so every
// SNG bit is deterministic, random inputs and modes against a window-level model.
module tb_bitstream_neuron_acc;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int L  = 8;
  localparam int AW = $clog2(N+1);
  localparam int WINDOW = 1 << L;

  logic          clk, n_rst, cfg_bipolar, start, wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [N-1:0]  neuron_input;
  logic          neuron_output, busy, count_valid;
  logic [L:0]    count_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [N-1:0] ins [WINDOW];

  bitstream_neuron_acc #(.INPUT_SIZE(N), .WIDTH(W), .STREAM_LOG2(L), .ACT_BITS(3), .SEED(0)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .cfg_bipolar   (cfg_bipolar),
    .start         (start),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .neuron_input  (neuron_input),
    .neuron_output (neuron_output),
    .busy          (busy),
    .count_out     (count_out),
    .count_valid   (count_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected ones count over one window; wb[k] is the constant SNG bit of slot k.
  function automatic int model_count(input bit bip, input logic [N:0] wb);
    int c = 0;
    int s = 4;
    bit tog = 1'b0;
    bit sum, act;
    int sel;
    for (int i = 0; i < WINDOW; i++) begin
      sel = i % (N + 1);
      if (!bip) sum = wb[N] | (|(wb[N-1:0] & ins[i]));
      else if (sel == N) sum = wb[N];
      else sum = (wb[sel] == ins[i][sel]);
      act = bip ? ((s >= 4) ? sum : tog) : sum;
      if (sum) s = (s < 7) ? s + 1 : 7;
      else     s = (s > 0) ? s - 1 : 0;
      tog = ~tog;
      c += int'(act);
    end
    return c;
  endfunction

  task automatic wr(input int addr, input logic [W-1:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic set_weights(input logic [N:0] wb);
    for (int k = 0; k <= N; k++) wr(k, wb[k] ? 16'hFFFF : 16'h0000);
  endtask

  task automatic fill_ins(input logic [N-1:0] v, input bit rnd);
    for (int i = 0; i < WINDOW; i++) ins[i] = rnd ? N'($urandom) : v;
  endtask

  // Returns at the first negedge after DONE (block back in IDLE).
  task automatic do_run(input bit mode, input bit hold_start, input int wr_at, input bit wr_with_start,
                        input int sw_addr, input logic [W-1:0] sw_data,
                        output int cnt_o, output int lat_o);
    int k;
    bit seen;
    k = 0; seen = 1'b0; lat_o = -1; cnt_o = -1;
    @(negedge clk);
    cfg_bipolar = mode; start = 1'b1;
    if (wr_with_start) begin wr_en = 1'b1; wr_addr = AW'(sw_addr); wr_data = sw_data; end
    while (!seen && k < 400) begin
      @(negedge clk);
      k++;
      if (!hold_start) start = 1'b0;
      wr_en = 1'b0;
      if (k - 1 == wr_at) begin wr_en = 1'b1; wr_addr = AW'(sw_addr); wr_data = sw_data; end
      neuron_input = (k <= WINDOW) ? ins[k-1] : '0;
      if (count_valid) begin seen = 1'b1; lat_o = k - 1; cnt_o = int'(count_out); end
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0; neuron_input = '0;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++; if (neuron_output !== 1'b0) begin n_err++; $display("FAIL reset_out got %b want 0", neuron_output); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (count_out !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", count_out); end
    n_cmp++; if (count_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", count_valid); end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_unipolar;
    int c, lat;
    set_weights(5'b00001);
    fill_ins(4'b0001, 1'b0);
    do_run(1'b0, 1'b0, -1, 1'b0, 0, '0, c, lat);
    n_cmp++; if (lat !== 257) begin n_err++; $display("FAIL uni_latency got %0d want 257", lat); end
    n_cmp++; if (c !== 256) begin n_err++; $display("FAIL uni_ones got %0d want 256", c); end
    fill_ins(4'b0000, 1'b0);
    do_run(1'b0, 1'b0, -1, 1'b0, 0, '0, c, lat);
    n_cmp++; if (c !== 0) begin n_err++; $display("FAIL uni_zero got %0d want 0", c); end
  endtask

  task automatic test_bipolar;
    int c, lat;
    set_weights(5'b11111);
    fill_ins(4'b1111, 1'b0);
    do_run(1'b1, 1'b0, -1, 1'b0, 0, '0, c, lat);
    n_cmp++; if (c !== 256) begin n_err++; $display("FAIL bip_all_one got %0d want 256", c); end
    set_weights(5'b01111);
    fill_ins(4'b0000, 1'b0);
    do_run(1'b1, 1'b0, -1, 1'b0, 0, '0, c, lat);
    n_cmp++; if (c !== 128) begin n_err++; $display("FAIL bip_toggle got %0d want 128", c); end
    n_cmp++; if (lat !== 257) begin n_err++; $display("FAIL bip_latency got %0d want 257", lat); end
  endtask

  task automatic test_random;
    int c, lat, exp;
    bit mode;
    logic [N:0] wb;
    for (int it = 0; it < 8; it++) begin
      mode = 1'($urandom);
      wb   = (N+1)'($urandom);
      set_weights(wb);
      fill_ins('0, 1'b1);
      exp = model_count(mode, wb);
      do_run(mode, 1'b0, -1, 1'b0, 0, '0, c, lat);
      n_cmp++;
      if (c !== exp || lat !== 257)
        begin n_err++; $display("FAIL rand_%0d mode=%0d wb=%b got %0d/lat %0d want %0d/lat 257", it, mode, wb, c, lat, exp); end
    end
  endtask

  task automatic test_write_protect;
    int c, lat, extra;
    set_weights(5'b00000);
    fill_ins(4'b0010, 1'b0);
    do_run(1'b0, 1'b0, 50, 1'b0, 1, 16'h1234, c, lat);
    n_cmp++; if (c !== 0) begin n_err++; $display("FAIL wp_first got %0d want 0", c); end
    // start held high through RUN and DONE must yield a single window
    do_run(1'b0, 1'b1, -1, 1'b0, 0, '0, c, lat);
    n_cmp++; if (c !== 0 || lat !== 257) begin n_err++; $display("FAIL wp_rerun got %0d/lat %0d want 0/lat 257", c, lat); end
    extra = 0;
    for (int i = 0; i < 300; i++) begin @(negedge clk); if (count_valid) extra++; end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL start_ignored extra pulses got %0d want 0", extra); end
    for (int a = N + 1; a < (1 << AW); a++) wr(a, 16'hFFFF);
    fill_ins(4'b1111, 1'b0);
    do_run(1'b0, 1'b0, -1, 1'b0, 0, '0, c, lat);
    n_cmp++; if (c !== 0) begin n_err++; $display("FAIL bad_addr got %0d want 0", c); end
  endtask

  task automatic test_back_to_back;
    int c, lat, k;
    bit seen;
    set_weights(5'b00000);
    fill_ins(4'b0000, 1'b0);
    do_run(1'b0, 1'b0, -1, 1'b1, N, 16'hFFFF, c, lat);
    n_cmp++; if (c !== 256) begin n_err++; $display("FAIL wr_with_start got %0d want 256", c); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_after_done busy got %b want 0", busy); end
    cfg_bipolar = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL restart busy got %b want 1", busy); end
    seen = 1'b0; k = 0;
    while (!seen && k < 400) begin @(negedge clk); k++; if (count_valid) seen = 1'b1; end
    n_cmp++;
    if (!seen || count_out !== 9'd256)
      begin n_err++; $display("FAIL restart_result seen=%0d got %0d want 256", seen, count_out); end
  endtask

  task automatic test_reset_midrun;
    int c, lat, pulses;
    set_weights(5'b11111);
    @(negedge clk);
    cfg_bipolar = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; neuron_input = 4'hF;
    repeat (99) @(negedge clk);
    n_cmp++; if (neuron_output !== 1'b1 || busy !== 1'b1)
      begin n_err++; $display("FAIL midrun_active out=%b busy=%b want 1/1", neuron_output, busy); end
    n_rst = 1'b0;
    #1;
    n_cmp++; if (neuron_output !== 1'b0 || busy !== 1'b0 || count_valid !== 1'b0 || count_out !== '0)
      begin n_err++; $display("FAIL midrun_reset out=%b busy=%b cv=%b cnt=%0d want all 0", neuron_output, busy, count_valid, count_out); end
    @(negedge clk);
    n_rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 300; i++) begin @(negedge clk); if (count_valid) pulses++; end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL midrun_no_valid got %0d want 0", pulses); end
    fill_ins(4'b1111, 1'b0);
    do_run(1'b0, 1'b0, -1, 1'b0, 0, '0, c, lat);
    n_cmp++; if (c !== 0) begin n_err++; $display("FAIL readback got %0d want 0", c); end
  endtask

  initial begin
    n_rst = 1'b0; cfg_bipolar = 1'b0; start = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; neuron_input = '0;
    test_reset;
    test_unipolar;
    test_bipolar;
    test_random;
    test_write_protect;
    test_back_to_back;
    test_reset_midrun;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
